// File: rtl/demux2_fifo.sv
// demux2_fifo: 1-to-2 word router with a DEPTH-entry FIFO per output; DEMUX2_FIFO_COUNT_EN adds push counters.
// Latency: a word pushed into an empty FIFO is visible on o*_valid/o*_data one cycle later.
// Backpressure: in_ready reflects only the FIFO selected by control; a full FIFO refuses pushes even when popping.
module demux2_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             control,
  input  logic [WIDTH-1:0] in_data,
  output logic             oa_valid,
  input  logic             oa_ready,
  output logic [WIDTH-1:0] oa_data,
  output logic             ob_valid,
  input  logic             ob_ready,
  output logic [WIDTH-1:0] ob_data,
  output logic [15:0]      cnt_a,
  output logic [15:0]      cnt_b
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]       full;
  logic [1:0]       vld;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [WIDTH-1:0] head [2];

  assign in_ready = control ? !full[1] : !full[0];
  assign push[0]  = in_valid && in_ready && !control;
  assign push[1]  = in_valid && in_ready && control;
  assign pop[0]   = vld[0] && oa_ready;
  assign pop[1]   = vld[1] && ob_ready;

  assign oa_valid = vld[0];
  assign oa_data  = head[0];
  assign ob_valid = vld[1];
  assign ob_data  = head[1];

  // Channel 0 feeds output A, channel 1 feeds output B.
  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    assign full[i] = (count == (AW+1)'(DEPTH));
    assign vld[i]  = (count != '0);
    assign head[i] = vld[i] ? mem[rd_ptr] : '0;

    // Storage is not reset; the empty state masks stale contents.
    always_ff @(posedge clk) begin
      if (push[i]) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + AW'(1);
        if (pop[i])  rd_ptr <= rd_ptr + AW'(1);
        if (push[i] && !pop[i])      count <= count + (AW+1)'(1);
        else if (!push[i] && pop[i]) count <= count - (AW+1)'(1);
      end
    end
  end

`ifdef DEMUX2_FIFO_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (push[0]) cnt_a <= cnt_a + 16'd1;
      if (push[1]) cnt_b <= cnt_b + 16'd1;
    end
  end
`else
  assign cnt_a = '0;
  assign cnt_b = '0;
`endif

endmodule

// File: tb/tb_demux2_fifo.sv
// Bench for demux2_fifo: directed vector table, reset/wrap/counter sequences, random traffic vs queue model.
module tb_demux2_fifo;
  localparam int W = 32;
  localparam int D = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          control = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          oa_ready = 1'b0;
  logic          ob_ready = 1'b0;
  logic          in_ready, oa_valid, ob_valid;
  logic [W-1:0]  oa_data, ob_data;
  logic [15:0]   cnt_a, cnt_b;

  demux2_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .control(control), .in_data(in_data),
    .oa_valid(oa_valid), .oa_ready(oa_ready), .oa_data(oa_data),
    .ob_valid(ob_valid), .ob_ready(ob_ready), .ob_data(ob_data),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

`ifdef DEMUX2_FIFO_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] got_a[$];
  logic [15:0] m_cnt_a, m_cnt_b;

  typedef struct {
    logic        v, c;
    logic [31:0] d;
    logic        ra, rb;
    logic        rdy, av;
    logic [31:0] ad;
    logic        bv;
    logic [31:0] bd;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; control = 1'b0; oa_ready = 1'b0; ob_ready = 1'b0;
    rst_n = 1'b0;
    qa.delete(); qb.delete(); got_a.delete();
    m_cnt_a = '0; m_cnt_b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Checks outputs against the queue model, then advances model and DUT one cycle.
  task automatic model_step();
    bit rdy_e, pa, pb, pu;
    #1;
    rdy_e = control ? (qb.size() < D) : (qa.size() < D);
    chk("in_ready", in_ready, rdy_e);
    chk("oa_valid", oa_valid, qa.size() != 0);
    chk("oa_data", oa_data, qa.size() != 0 ? qa[0] : 32'h0);
    chk("ob_valid", ob_valid, qb.size() != 0);
    chk("ob_data", ob_data, qb.size() != 0 ? qb[0] : 32'h0);
    chk("cnt_a", cnt_a, COUNT_EN ? m_cnt_a : 16'h0);
    chk("cnt_b", cnt_b, COUNT_EN ? m_cnt_b : 16'h0);
    pa = (qa.size() != 0) && oa_ready;
    pb = (qb.size() != 0) && ob_ready;
    pu = in_valid && rdy_e;
    if (oa_valid && oa_ready) got_a.push_back(oa_data);
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (pu) begin
      if (control) begin qb.push_back(in_data); m_cnt_b++; end
      else         begin qa.push_back(in_data); m_cnt_a++; end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            v     c     d       ra    rb    rdy   av    ad      bv    bd
    tbl[0]  = '{1'b1, 1'b0, 32'h1,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 32'h2,  1'b1, 1'b1, 1'b1, 1'b1, 32'h1,  1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h2};
    tbl[3]  = '{1'b1, 1'b0, 32'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'hA1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 32'hB0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'hA2, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b1, 32'hB0};
    tbl[8]  = '{1'b1, 1'b0, 32'hA2, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA1, 1'b1, 32'hB0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hA2, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};

    // Reset state, then reset asserted while A holds a word.
    do_reset();
    #1;
    chk("rst oa_valid", oa_valid, 1'b0);
    chk("rst ob_valid", ob_valid, 1'b0);
    chk("rst cnt_a", cnt_a, 16'h0);
    in_valid = 1'b1; control = 1'b0; in_data = 32'h55;
    model_step();
    in_valid = 1'b0;
    #1 chk("pre-reset oa_valid", oa_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst oa_valid", oa_valid, 1'b0);
    chk("midrst oa_data", oa_data, 32'h0);
    chk("midrst cnt_a", cnt_a, 16'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    control = 1'b0;
    #1 chk("post-rst in_ready c0", in_ready, 1'b1);
    control = 1'b1;
    #1 chk("post-rst in_ready c1", in_ready, 1'b1);

    // Directed table: routing, full/backpressure, full with simultaneous pop.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].v; control = tbl[i].c; in_data = tbl[i].d;
      oa_ready = tbl[i].ra; ob_ready = tbl[i].rb;
      #1;
      chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("vec%0d oa_valid", i), oa_valid, tbl[i].av);
      chk($sformatf("vec%0d oa_data", i), oa_data, tbl[i].ad);
      chk($sformatf("vec%0d ob_valid", i), ob_valid, tbl[i].bv);
      chk($sformatf("vec%0d ob_data", i), ob_data, tbl[i].bd);
      @(posedge clk);
      #1;
    end

    // Wrap-around: ten words to A with consumer readiness toggling.
    do_reset();
    begin
      int idx = 0;
      for (int k = 0; k < 200 && got_a.size() < 10; k++) begin
        in_valid = (idx < 10);
        control  = 1'b0;
        in_data  = 32'h10 + idx;
        oa_ready = k[0];
        #1;
        if (in_valid && in_ready) idx++;
        model_step();
      end
      in_valid = 1'b0;
      chk("wrap count", got_a.size(), 10);
      for (int i = 0; i < got_a.size() && i < 10; i++)
        chk($sformatf("wrap word%0d", i), got_a[i], 32'h10 + i);
    end

    // Random traffic against the queue model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      control  = $urandom_range(0, 1);
      in_data  = $urandom;
      oa_ready = ($urandom_range(0, 2) != 0);
      ob_ready = ($urandom_range(0, 1) != 0);
      model_step();
    end
    in_valid = 1'b0;

    // Counter wrap on A.
    do_reset();
`ifdef DEMUX2_FIFO_COUNT_EN
    in_valid = 1'b1; control = 1'b0; oa_ready = 1'b1; ob_ready = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt_a preset", cnt_a, 16'hFFFF);
    chk("cnt_b preset", cnt_b, 16'h0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("cnt_a wrap", cnt_a, 16'h0000);
    chk("cnt_b after wrap", cnt_b, 16'h0);
`else
    in_valid = 1'b1; control = 1'b0; oa_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1 control = 1'b1;
    repeat (20) @(posedge clk);
    #1 in_valid = 1'b0;
    chk("cnt_a tied", cnt_a, 16'h0);
    chk("cnt_b tied", cnt_b, 16'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
